// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
// Module   : mine_placer
// Brief    : Random mine-field generator driven by a free-running 16-bit LFSR.
//            Optional: MINE_PLACER_NEIGHBOUR_EXCL_EN protects the 3x3 block
//            around the exclusion cell instead of the single cell.
// Revision : 1.0 - initial release
// ============================================================================
module mine_placer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_SIDE  = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [1:0]                         level,
   input  logic [5:0]                         mines,
   input  logic [4:0]                         excl_x,
   input  logic [4:0]                         excl_y,
   output logic                               busy,
   output logic                               done,
   output logic [5:0]                         placed_cnt,
   output logic [MAX_SIDE-1:0][MAX_SIDE-1:0]  mine_arr
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_CLEAR  = 2'd1;
   localparam logic [1:0] c_PLACE  = 2'd2;
   localparam logic [1:0] c_FINISH = 2'd3;

   logic [1:0]                        r_state, w_next;
   logic [15:0]                       r_lfsr;
   logic [1:0]                        r_level;
   logic [5:0]                        r_target;
   logic [4:0]                        r_ex, r_ey;
   logic [5:0]                        r_cnt;
   logic [MAX_SIDE-1:0][MAX_SIDE-1:0] r_arr;

   logic       w_start_ok;
   logic [4:0] w_side_in, w_side;
   logic       w_excl_in, w_excl_ok;
   logic [8:0] w_cells, w_prot, w_limit;
   logic [5:0] w_target;
   logic [3:0] w_cx, w_cy;
   logic       w_in_board, w_protected, w_accept;

   function automatic logic [4:0] side_of(input logic [1:0] lvl);
      case (lvl)
         2'd1:    return 5'd8;
         2'd2:    return 5'd10;
         2'd3:    return 5'd16;
         default: return 5'd0;
      endcase
   endfunction

   // Target clamp computed from the raw inputs so it can be latched on accept.
   always_comb begin
      w_side_in = side_of(level);
      w_excl_in = (excl_x < w_side_in) && (excl_y < w_side_in);
      w_cells   = {4'b0, w_side_in} * {4'b0, w_side_in};
`ifdef MINE_PLACER_NEIGHBOUR_EXCL_EN
      begin
         logic [1:0] nx, ny;
         nx = 2'd1 + 2'(excl_x != 5'd0) + 2'(({1'b0, excl_x} + 6'd1) < {1'b0, w_side_in});
         ny = 2'd1 + 2'(excl_y != 5'd0) + 2'(({1'b0, excl_y} + 6'd1) < {1'b0, w_side_in});
         w_prot = w_excl_in ? ({7'b0, nx} * {7'b0, ny}) : 9'd0;
      end
`else
      w_prot = w_excl_in ? 9'd1 : 9'd0;
`endif
      w_limit  = w_cells - w_prot;
      w_target = ({3'b0, mines} > w_limit) ? w_limit[5:0] : mines;
   end

   // Candidate evaluation against the latched game parameters.
   always_comb begin
      w_cx       = r_lfsr[3:0];
      w_cy       = r_lfsr[7:4];
      w_side     = side_of(r_level);
      w_in_board = ({1'b0, w_cx} < w_side) && ({1'b0, w_cy} < w_side);
      w_excl_ok  = (r_ex < w_side) && (r_ey < w_side);
`ifdef MINE_PLACER_NEIGHBOUR_EXCL_EN
      w_protected = w_excl_ok
                 && (({2'b0, w_cx} + 6'd1) >= {1'b0, r_ex}) && ({2'b0, w_cx} <= ({1'b0, r_ex} + 6'd1))
                 && (({2'b0, w_cy} + 6'd1) >= {1'b0, r_ey}) && ({2'b0, w_cy} <= ({1'b0, r_ey} + 6'd1));
`else
      w_protected = w_excl_ok && ({1'b0, w_cx} == r_ex) && ({1'b0, w_cy} == r_ey);
`endif
      w_accept   = (r_state == c_PLACE) && w_in_board && !r_arr[w_cy][w_cx] && !w_protected;
      w_start_ok = (r_state == c_IDLE) && start && (level != 2'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:   if (w_start_ok) w_next = c_CLEAR;
         c_CLEAR:  w_next = (r_target == 6'd0) ? c_FINISH : c_PLACE;
         c_PLACE:  if (w_accept && ((r_cnt + 6'd1) == r_target)) w_next = c_FINISH;
         c_FINISH: w_next = c_IDLE;
         default:  w_next = c_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != c_IDLE);
      done = (r_state == c_FINISH);
   end

   // LFSR runs in every state so the field depends on when start arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr   <= LFSR_SEED;
         r_level  <= 2'd0;
         r_target <= 6'd0;
         r_ex     <= 5'd0;
         r_ey     <= 5'd0;
         r_cnt    <= 6'd0;
         r_arr    <= '0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         if (w_start_ok) begin
            r_level  <= level;
            r_target <= w_target;
            r_ex     <= excl_x;
            r_ey     <= excl_y;
         end
         if (r_state == c_CLEAR) begin
            r_arr <= '0;
            r_cnt <= 6'd0;
         end else if (w_accept) begin
            r_arr[w_cy][w_cx] <= 1'b1;
            r_cnt             <= r_cnt + 6'd1;
         end
      end
   end

   assign placed_cnt = r_cnt;
   assign mine_arr   = r_arr;

endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mine_placer
// Brief    : Directed, table-driven bench for mine_placer with an LFSR-based
//            placement model and hand-written protocol sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mine_placer;

   localparam logic [15:0] SEED = 16'hACE1;
`ifdef MINE_PLACER_NEIGHBOUR_EXCL_EN
   localparam int NB = 1;
`else
   localparam int NB = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        level;
   logic [5:0]        mines;
   logic [4:0]        excl_x, excl_y;
   logic              busy, done;
   logic [5:0]        placed_cnt;
   logic [15:0][15:0] mine_arr;

   always #5 clk = ~clk;

   mine_placer #(.LFSR_SEED(SEED), .MAX_SIDE(16)) dut (
      .clk(clk), .rst(rst), .start(start), .level(level), .mines(mines),
      .excl_x(excl_x), .excl_y(excl_y), .busy(busy), .done(done),
      .placed_cnt(placed_cnt), .mine_arr(mine_arr)
   );

   int                n_checks = 0;
   int                n_errors = 0;
   logic [5:0]        prev_cnt;
   logic [15:0][15:0] last_arr;
   logic [15:0]       m_lfsr;

   typedef struct {
      logic [1:0] level;
      logic [5:0] mines;
      logic [4:0] ex;
      logic [4:0] ey;
      int         side;
      int         exp_cnt;
      int         poke_at;
   } vec_t;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   always @(posedge clk or negedge rst)
      if (!rst) m_lfsr <= SEED;
      else      m_lfsr <= lfsr_step(m_lfsr);

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_prot(input int x, input int y, input int ex, input int ey, input int side);
      if (ex >= side || ey >= side) return 1'b0;
      if (NB != 0) return (x >= ex - 1) && (x <= ex + 1) && (y >= ey - 1) && (y <= ey + 1);
      return (x == ex) && (y == ey);
   endfunction

   function automatic void model_place(input logic [15:0] l0, input int side, input int target,
                                       input int ex, input int ey,
                                       output logic [15:0][15:0] arr, output int ncand);
      logic [15:0] l;
      int placed, x, y;
      l = l0; placed = 0; arr = '0; ncand = 0;
      while (placed < target && ncand < 60000) begin
         x = int'(l[3:0]);
         y = int'(l[7:4]);
         ncand++;
         if (x < side && y < side && !arr[y][x] && !is_prot(x, y, ex, ey, side)) begin
            arr[y][x] = 1'b1;
            placed++;
         end
         l = lfsr_step(l);
      end
   endfunction

   task automatic run_game(input vec_t v, input string tag);
      logic [15:0]       l0;
      logic [15:0][15:0] exp_arr, mask;
      int                ncand, done_cyc, extra_done;
      bit                busy_bad;
      @(negedge clk);
      l0 = m_lfsr;
      level = v.level; mines = v.mines; excl_x = v.ex; excl_y = v.ey; start = 1'b1;
      model_place(lfsr_step(lfsr_step(l0)), v.side, v.exp_cnt, int'(v.ex), int'(v.ey), exp_arr, ncand);
      done_cyc = -1; busy_bad = 1'b0;
      for (int cyc = 1; cyc <= 20000 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         start = (v.poke_at != 0 && cyc == v.poke_at);
         if (start) begin level = 2'd3; mines = 6'd5; excl_x = 5'd0; excl_y = 5'd0; end
         if (cyc == 1) check({tag, "_hold_cnt"}, 256'(placed_cnt), 256'(prev_cnt));
         if (cyc == 1) check({tag, "_hold_arr"}, mine_arr, last_arr);
         if (cyc == 2) check({tag, "_clear_cnt"}, 256'(placed_cnt), 256'd0);
         if (cyc == 2 && v.exp_cnt != 0) check({tag, "_clear_arr"}, mine_arr, 256'd0);
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (done === 1'b1) done_cyc = cyc;
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 256'(done_cyc), 256'(2 + ncand));
      check({tag, "_busy_span"}, 256'(busy_bad), 256'd0);
      check({tag, "_cnt"}, 256'(placed_cnt), 256'(v.exp_cnt));
      check({tag, "_popcount"}, 256'($countones(mine_arr)), 256'(v.exp_cnt));
      check({tag, "_arr"}, mine_arr, exp_arr);
      if (int'(v.ex) < v.side && int'(v.ey) < v.side)
         check({tag, "_excl_cell"}, 256'(mine_arr[v.ey[3:0]][v.ex[3:0]]), 256'd0);
      mask = '0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++)
            if (x >= v.side || y >= v.side) mask[y][x] = 1'b1;
      check({tag, "_outside"}, mine_arr & mask, 256'd0);
      @(negedge clk);
      check({tag, "_done_low"}, 256'({done, busy}), 256'd0);
      extra_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      check({tag, "_single_done"}, 256'(extra_done), 256'd0);
      check({tag, "_stable"}, mine_arr, exp_arr);
      prev_cnt = 6'(v.exp_cnt);
      last_arr = exp_arr;
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation ran past its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[9];
      bit   seen;
      int   nz;
      vecs[0] = '{2'd1, 6'd10, 5'd3,  5'd4,  8,  10, 0};
      vecs[1] = '{2'd3, 6'd40, 5'd15, 5'd15, 16, 40, 0};
      vecs[2] = '{2'd3, 6'd25, 5'd7,  5'd8,  16, 25, 0};
      vecs[3] = '{2'd2, 6'd0,  5'd1,  5'd1,  10, 0,  0};
      vecs[4] = '{2'd1, 6'd63, 5'd0,  5'd0,  8,  (NB != 0) ? 60 : 63, 0};
      vecs[5] = '{2'd1, 6'd63, 5'd3,  5'd3,  8,  (NB != 0) ? 55 : 63, 0};
      vecs[6] = '{2'd2, 6'd30, 5'd12, 5'd3,  10, 30, 0};
      vecs[7] = '{2'd1, 6'd63, 5'd9,  5'd2,  8,  63, 0};
      vecs[8] = '{2'd1, 6'd10, 5'd3,  5'd4,  8,  10, 4};

      rst = 1'b0; start = 1'b0; level = 2'd0; mines = 6'd0; excl_x = 5'd0; excl_y = 5'd0;
      prev_cnt = 6'd0; last_arr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      nz = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || placed_cnt !== 6'd0 || mine_arr !== '0) nz++;
      end
      check("reset_idle_quiet", 256'(nz), 256'd0);
      check("reset_busy", 256'(busy), 256'd0);
      check("reset_done", 256'(done), 256'd0);
      check("reset_cnt", 256'(placed_cnt), 256'd0);
      check("reset_arr", mine_arr, 256'd0);

      @(negedge clk);
      level = 2'd0; mines = 6'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      check("lvl0_ignored", 256'(seen), 256'd0);
      check("lvl0_arr", mine_arr, 256'd0);

      for (int i = 0; i < 9; i++) run_game(vecs[i], $sformatf("vec%0d", i));

      @(negedge clk);
      level = 2'd3; mines = 6'd40; excl_x = 5'd2; excl_y = 5'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_pre_busy", 256'(busy), 256'd1);
      rst = 1'b0;
      #1;
      check("rst_busy", 256'(busy), 256'd0);
      check("rst_done", 256'(done), 256'd0);
      check("rst_cnt", 256'(placed_cnt), 256'd0);
      check("rst_arr", mine_arr, 256'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      check("rst_no_done", 256'(seen), 256'd0);
      prev_cnt = 6'd0; last_arr = '0;
      run_game(vecs[0], "after_rst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
